// File: rtl/sirv_gnrl_pkg.sv
// Shared constants for the general-purpose pipeline building blocks.
// DP_MAX bounds the stage count; SKID_DEPTH is the capacity of the optional
// input skid register (enabled by SIRV_GNRL_PIPE_SKID_EN).
package sirv_gnrl_pkg;

    localparam int DP_MAX     = 8;
    localparam int SKID_DEPTH = 1;

endpackage

// File: rtl/sirv_gnrl_pipe_stages_dff.sv
// Storage primitives for the pipe stages:
//   sirv_gnrl_dfflr_s : load-enabled flop with synchronous active-high reset
//   sirv_gnrl_dffl    : load-enabled flop without reset (payload data)
module sirv_gnrl_dfflr_s #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    // Reset wins over load; otherwise capture dnxt when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

module sirv_gnrl_dffl #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    // Payload register: no reset, contents only meaningful with a valid bit.
    always_ff @(posedge clk) begin
        if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/sirv_gnrl_pipe_stages.sv
// Parameterised valid/ready register pipeline.
//   DW : payload width, DP : number of register stages (0 = pass-through).
// Handshake: a payload moves across an interface only in a cycle where both
// vld and rdy are high; upstream may change i_vld/i_dat while i_rdy is low.
// Optional build macro SIRV_GNRL_PIPE_SKID_EN adds a one-entry skid register
// ahead of stage 1 so that i_rdy comes straight from a flop.
module sirv_gnrl_pipe_stages
    import sirv_gnrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int DP = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    output logic          o_busy
);

    // Stage count is bounded by the package limit.
    localparam int NS = (DP > DP_MAX) ? DP_MAX : DP;

    generate
        if (NS == 0) begin : g_pass
            // No storage: wires straight through, flush still blocks both sides.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign o_vld  = i_vld & ~i_flush;
            assign o_dat  = i_dat;
            assign i_rdy  = o_rdy & ~i_flush;
            assign o_busy = 1'b0;
        end else begin : g_pipe
            // vld[0]/dat[0] is the source feeding stage 1; rdy[k] says stage k
            // can load this cycle; rdy[NS+1] is the downstream ready.
            logic [NS:0]   vld;
            logic [NS+1:1] rdy;
            logic [DW-1:0] dat [0:NS];
            logic          src_busy;

            assign rdy[NS+1] = o_rdy;

`ifdef SIRV_GNRL_PIPE_SKID_EN
            // Skid entry catches an accepted payload that stage 1 cannot take,
            // which lets i_rdy depend only on the skid valid flop. A payload
            // accepted during a flush cycle is discarded along with the rest.
            logic          skid_vld;
            logic [DW-1:0] skid_dat;
            logic          skid_push;
            logic          skid_pop;

            assign skid_push = ~skid_vld & i_vld & ~rdy[1];
            assign skid_pop  = skid_vld & rdy[1];

            sirv_gnrl_dfflr_s #(.DW(1)) u_skid_vld (
                .clk  (clk),
                .rst  (rst),
                .lden (i_flush | skid_push | skid_pop),
                .dnxt (skid_push & ~i_flush),
                .qout (skid_vld)
            );

            sirv_gnrl_dffl #(.DW(DW)) u_skid_dat (
                .clk  (clk),
                .lden (skid_push & ~i_flush),
                .dnxt (i_dat),
                .qout (skid_dat)
            );

            // Stage 1 drains the skid entry before taking fresh input.
            assign vld[0]   = skid_vld | i_vld;
            assign dat[0]   = skid_vld ? skid_dat : i_dat;
            assign i_rdy    = ~skid_vld;
            assign src_busy = skid_vld;
`else
            assign vld[0]   = i_vld;
            assign dat[0]   = i_dat;
            assign i_rdy    = rdy[1] & ~i_flush;
            assign src_busy = 1'b0;
`endif

            for (genvar k = 1; k <= NS; k++) begin : g_stage
                logic ld;

                // A stage loads when empty or when the next one takes its payload.
                assign ld     = ~vld[k] | rdy[k+1];
                assign rdy[k] = ld;

                sirv_gnrl_dfflr_s #(.DW(1)) u_vld (
                    .clk  (clk),
                    .rst  (rst),
                    .lden (ld | i_flush),
                    .dnxt (vld[k-1] & ~i_flush),
                    .qout (vld[k])
                );

                // Data only moves with a valid payload and never on flush.
                sirv_gnrl_dffl #(.DW(DW)) u_dat (
                    .clk  (clk),
                    .lden (ld & vld[k-1] & ~i_flush),
                    .dnxt (dat[k-1]),
                    .qout (dat[k])
                );
            end

            assign o_vld  = vld[NS] & ~i_flush;
            assign o_dat  = dat[NS];
            assign o_busy = (|vld[NS:1]) | src_busy;
        end
    endgenerate

endmodule

// File: tb/tb_sirv_gnrl_pipe_stages.sv
// Directed bench for sirv_gnrl_pipe_stages at DP = 0, 2, 3, 4 (and DP = 1
// with the skid register when SIRV_GNRL_PIPE_SKID_EN is defined).
module tb_sirv_gnrl_pipe_stages;

    localparam int DW = 8;

`ifdef SIRV_GNRL_PIPE_SKID_EN
    localparam int CAP3    = 4;
    localparam bit FL_IRDY = 1'b1;
`else
    localparam int CAP3    = 3;
    localparam bit FL_IRDY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Clock and reset
    always #5 clk = ~clk;

    logic          a0_flush = 0, a0_ivld = 0, a0_irdy, a0_ovld, a0_ordy = 0, a0_busy;
    logic [DW-1:0] a0_idat = 0, a0_odat;
    logic          a2_flush = 0, a2_ivld = 0, a2_irdy, a2_ovld, a2_ordy = 0, a2_busy;
    logic [DW-1:0] a2_idat = 0, a2_odat;
    logic          a3_flush = 0, a3_ivld = 0, a3_irdy, a3_ovld, a3_ordy = 0, a3_busy;
    logic [DW-1:0] a3_idat = 0, a3_odat;
    logic          a4_flush = 0, a4_ivld = 0, a4_irdy, a4_ovld, a4_ordy = 0, a4_busy;
    logic [DW-1:0] a4_idat = 0, a4_odat;

    sirv_gnrl_pipe_stages #(.DW(DW), .DP(0)) u_dp0 (
        .clk(clk), .rst(rst), .i_flush(a0_flush), .i_vld(a0_ivld), .i_rdy(a0_irdy),
        .i_dat(a0_idat), .o_vld(a0_ovld), .o_rdy(a0_ordy), .o_dat(a0_odat), .o_busy(a0_busy));
    sirv_gnrl_pipe_stages #(.DW(DW), .DP(2)) u_dp2 (
        .clk(clk), .rst(rst), .i_flush(a2_flush), .i_vld(a2_ivld), .i_rdy(a2_irdy),
        .i_dat(a2_idat), .o_vld(a2_ovld), .o_rdy(a2_ordy), .o_dat(a2_odat), .o_busy(a2_busy));
    sirv_gnrl_pipe_stages #(.DW(DW), .DP(3)) u_dp3 (
        .clk(clk), .rst(rst), .i_flush(a3_flush), .i_vld(a3_ivld), .i_rdy(a3_irdy),
        .i_dat(a3_idat), .o_vld(a3_ovld), .o_rdy(a3_ordy), .o_dat(a3_odat), .o_busy(a3_busy));
    sirv_gnrl_pipe_stages #(.DW(DW), .DP(4)) u_dp4 (
        .clk(clk), .rst(rst), .i_flush(a4_flush), .i_vld(a4_ivld), .i_rdy(a4_irdy),
        .i_dat(a4_idat), .o_vld(a4_ovld), .o_rdy(a4_ordy), .o_dat(a4_odat), .o_busy(a4_busy));

`ifdef SIRV_GNRL_PIPE_SKID_EN
    logic          s1_flush = 0, s1_ivld = 0, s1_irdy, s1_ovld, s1_ordy = 0, s1_busy;
    logic [DW-1:0] s1_idat = 0, s1_odat;
    sirv_gnrl_pipe_stages #(.DW(DW), .DP(1)) u_sk1 (
        .clk(clk), .rst(rst), .i_flush(s1_flush), .i_vld(s1_ivld), .i_rdy(s1_irdy),
        .i_dat(s1_idat), .o_vld(s1_ovld), .o_rdy(s1_ordy), .o_dat(s1_odat), .o_busy(s1_busy));
`endif

    // Scoreboard
    logic [DW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Driver helper: move to the next negedge, let combinational outputs settle.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    logic [DW-1:0] vec31 [0:2];
    logic [DW-1:0] nxt;
    int            acc;
    logic [DW-1:0] e;
    logic          rdy_a;

    initial begin
        vec31[0] = 8'h11; vec31[1] = 8'h22; vec31[2] = 8'h33;

        // Reset state
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        settle();
        check("rst_dp2_ovld", a2_ovld, 0);
        check("rst_dp2_busy", a2_busy, 0);
        check("rst_dp2_irdy", a2_irdy, 1);
        check("rst_dp3_busy", a3_busy, 0);

        // DP=2 streaming: inputs on cycles 0..2, outputs on cycles 2..4
        a2_ordy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            a2_ivld = (c < 3);
            a2_idat = (c < 3) ? vec31[c] : 8'hEE;
            settle();
            check("dp2_irdy", a2_irdy, 1);
            if (c >= 2 && c <= 4) begin
                check("dp2_ovld", a2_ovld, 1);
                check("dp2_odat", a2_odat, vec31[c-2]);
            end else begin
                check("dp2_ovld_idle", a2_ovld, 0);
            end
        end
        a2_ivld = 1'b0;

        // DP=3 fill with downstream stalled, then drain in order
        a3_ordy = 1'b0;
        nxt = 8'h40;
        acc = 0;
        for (int c = 0; c < 7; c++) begin
            step();
            a3_ivld = 1'b1;
            a3_idat = nxt;
            settle();
            check("dp3_fill_irdy", a3_irdy, (acc < CAP3) ? 1 : 0);
            check("dp3_fill_ovld", a3_ovld, (c >= 3) ? 1 : 0);
            if (a3_irdy) begin
                exp_q.push_back(nxt);
                nxt = nxt + 8'd1;
                acc++;
            end
        end
        check("dp3_full_busy", a3_busy, 1);
        check("dp3_accepted", acc, CAP3);
        step();
        a3_ivld = 1'b0;
        a3_idat = 8'hFF;
        a3_ordy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            if (a3_ovld) begin
                if (exp_q.size() == 0) begin
                    check("dp3_extra_out", a3_odat, 8'h00);
                end else begin
                    e = exp_q.pop_front();
                    check("dp3_drain_dat", a3_odat, e);
                end
            end
            step();
        end
        check("dp3_drain_left", exp_q.size(), 0);
        settle();
        check("dp3_drain_busy", a3_busy, 0);

        // DP=2 flush of a full pipe holding 0x0A, 0x0B
        a2_ordy = 1'b0;
        step(); a2_ivld = 1'b1; a2_idat = 8'h0A;
        step(); a2_ivld = 1'b1; a2_idat = 8'h0B;
        step(); a2_ivld = 1'b0; a2_idat = 8'h00;
        settle();
        check("fl_full_ovld", a2_ovld, 1);
        check("fl_full_dat", a2_odat, 8'h0A);
        a2_flush = 1'b1;
        settle();
        check("fl_ovld", a2_ovld, 0);
        check("fl_irdy", a2_irdy, FL_IRDY);
        step();
        a2_flush = 1'b0;
        a2_ordy  = 1'b1;
        settle();
        check("fl_busy_next", a2_busy, 0);
        check("fl_irdy_next", a2_irdy, 1);
        for (int c = 0; c < 3; c++) begin
            check("fl_no_old", a2_ovld, 0);
            step();
            settle();
        end
        a2_ivld = 1'b1; a2_idat = 8'h5C;
        step();
        a2_ivld = 1'b0;
        step();
        settle();
        check("fl_new_ovld", a2_ovld, 1);
        check("fl_new_dat", a2_odat, 8'h5C);

        // DP=4 reset with three payloads in flight (rst beats a live input)
        a4_ordy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            a4_ivld = 1'b1;
            a4_idat = 8'h70 + 8'(c);
        end
        step();
        settle();
        check("r4_busy_before", a4_busy, 1);
        rst = 1'b1;
        a4_ivld = 1'b1;
        step();
        rst = 1'b0;
        a4_ivld = 1'b0;
        settle();
        check("r4_ovld", a4_ovld, 0);
        check("r4_busy", a4_busy, 0);
        check("r4_irdy", a4_irdy, 1);
        a4_ordy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            settle();
            check("r4_no_stale", a4_ovld, 0);
        end

        // DP=0 pass-through, random handshake values
        for (int c = 0; c < 16; c++) begin
            step();
            a0_ivld = 1'($urandom_range(0, 1));
            a0_ordy = 1'($urandom_range(0, 1));
            a0_idat = 8'($urandom_range(0, 255));
            settle();
            check("p0_ovld", a0_ovld, a0_ivld);
            check("p0_odat", a0_odat, a0_idat);
            check("p0_irdy", a0_irdy, a0_ordy);
            check("p0_busy", a0_busy, 0);
        end
        a0_ivld = 1'b1; a0_ordy = 1'b1; a0_flush = 1'b1;
        settle();
        check("p0_fl_ovld", a0_ovld, 0);
        check("p0_fl_irdy", a0_irdy, 0);
        a0_flush = 1'b0;

`ifdef SIRV_GNRL_PIPE_SKID_EN
        // DP=1 with skid: o_rdy toggling, i_rdy only moves on clock edges
        nxt = 8'h01;
        exp_q.delete();
        for (int c = 0; c < 12; c++) begin
            step();
            s1_ivld = 1'b1;
            s1_idat = nxt;
            s1_ordy = (c % 2 == 0);
            settle();
            rdy_a = s1_irdy;
            if (s1_ovld && s1_ordy) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                check("sk_dat", s1_odat, e);
            end
            if (s1_irdy) begin
                exp_q.push_back(nxt);
                nxt = nxt + 8'd1;
            end
            s1_ordy = ~s1_ordy;
            #2;
            check("sk_rdy_stable", s1_irdy, rdy_a);
            s1_ordy = ~s1_ordy;
        end
        step();
        s1_ivld = 1'b0;
        s1_ordy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            settle();
            if (s1_ovld) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                check("sk_drain", s1_odat, e);
            end
            step();
        end
        check("sk_left", exp_q.size(), 0);
`endif

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sirv_gnrl_pipe_stages.md
SIRV_GNRL_PIPE_STAGES -- requirements
Module: sirv_gnrl_pipe_stages

Interface
REQ-001 Parameter DW, default 32, payload width in bits, legal 1..1024.
REQ-002 Parameter DP, default 2, number of register stages, legal 0..8; DP=0 is a combinational pass-through.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_flush  input  1  synchronous pipeline flush.
REQ-006 i_vld  input  1  upstream payload valid.
REQ-007 i_rdy  output  1  stage accepts payload this cycle.
REQ-008 i_dat  input  DW  upstream payload.
REQ-009 o_vld  output  1  downstream payload valid.
REQ-010 o_rdy  input  1  downstream accepts payload.
REQ-011 o_dat  output  DW  downstream payload.
REQ-012 o_busy  output  1  high when any stage (or skid register) holds a valid payload.

Function
REQ-013 A transfer SHALL occur on an interface only in a cycle where vld and rdy are both high; i_vld and i_dat SHALL NOT be assumed stable while i_rdy is low.
REQ-014 Stage k (1..DP) SHALL hold a valid bit v[k] and a data register d[k]; stage k SHALL load when ~v[k] | rdy[k+1], where rdy[DP+1] = o_rdy.
REQ-015 On load, v[k] SHALL take v[k-1] (v[0] = i_vld) and d[k] SHALL take d[k-1] (d[0] = i_dat); d[k] SHALL be written only when the incoming valid is high.
REQ-016 o_vld = v[DP], o_dat = d[DP]; i_rdy = ~v[1] | rdy[2] (no skid).
REQ-017 Latency SHALL be exactly DP cycles from input transfer to o_vld with o_rdy held high; throughput SHALL be one payload per cycle.
REQ-018 With o_rdy low the pipe SHALL fill bubbles first: i_rdy stays high until all DP stages are valid, then drops in the same cycle.
REQ-019 Payload order SHALL be preserved; no payload SHALL be dropped or duplicated except by flush or reset.
REQ-020 i_flush high: i_rdy and o_vld SHALL be forced low that cycle; all v[k] (and skid valid) SHALL be 0 next cycle; data registers unchanged.
REQ-021 DP=0: o_vld = i_vld & ~i_flush, o_dat = i_dat, i_rdy = o_rdy & ~i_flush, o_busy = 0, no state.
REQ-022 o_busy SHALL be the OR of all valid bits, registered-only (no combinational path from inputs).

Reset
REQ-023 rst high on a clock edge SHALL clear every valid bit and the skid valid; o_vld = 0 and o_busy = 0 from the following cycle; i_rdy SHALL be high the cycle after reset.
REQ-024 Data registers SHALL NOT be reset; o_dat is don't-care while o_vld = 0.
REQ-025 Reset mid-stream SHALL discard all held payloads; rst SHALL take priority over i_flush and any load.

Configuration
REQ-026 Macro SIRV_GNRL_PIPE_SKID_EN SHALL, when defined and DP >= 1, insert a one-entry skid register ahead of stage 1 so that i_rdy is a pure register output (i_rdy = ~skid_vld).
REQ-027 With skid: an accepted payload that stage 1 cannot load SHALL go to the skid register; stage 1 SHALL load from skid before i_dat; skid adds no latency when unstalled; fill capacity becomes DP+1.
REQ-028 Without SIRV_GNRL_PIPE_SKID_EN, behaviour SHALL be exactly REQ-014..REQ-022 with combinational i_rdy.

Structure
REQ-029 Stage storage SHALL reuse sirv_gnrl_dfflr for valid bits (replaced by synchronous active-high equivalent sirv_gnrl_dfflr_s, the one natural sub-module) and sirv_gnrl_dffl for data.
REQ-030 A shared package sirv_gnrl_pkg SHALL hold DP_MAX = 8 and the skid capacity constant; no typedefs beyond these.

Verification
REQ-031 DP=2, o_rdy=1, i_dat 0x11,0x22,0x33 on consecutive cycles -> o_dat 0x11,0x22,0x33 on cycles 2,3,4, o_vld continuous.
REQ-032 DP=3, o_rdy=0, i_vld=1 continuous -> exactly 3 transfers (4 with skid) then i_rdy=0; o_rdy=1 -> values emerge in order, no loss.
REQ-033 DP=2, pipe full with 0xA,0xB, i_flush one cycle -> o_vld=0, i_rdy=0 that cycle, o_busy=0 next cycle, 0xA/0xB never seen.
REQ-034 DP=4, rst asserted with 3 valid payloads -> o_vld=0, o_busy=0 next cycle, i_rdy=1.
REQ-035 DP=0, random i_vld/o_rdy -> o_dat==i_dat, o_vld==i_vld, i_rdy==o_rdy every cycle.
REQ-036 SKID_EN, DP=1, o_rdy toggling 1,0,1,0 with i_vld=1 and incrementing data -> i_rdy changes only on clock edges, sequence intact.
